// File: rtl/id_ex_hazard_reg_pkg.sv
// Shared pipeline constants: forwarding selects, control-bundle bit map, x0 index.
package id_ex_hazard_reg_pkg;

  // EX-stage forwarding mux select encodings
  typedef enum logic [1:0] {
    Reg_src = 2'd0,
    EX_src  = 2'd1,
    MEM_src = 2'd2
  } fwd_src_e;

  // Decoded control bundle bit positions
  localparam int unsigned CTRL_MEM_READ   = 0;
  localparam int unsigned CTRL_MEM_WRITE  = 1;
  localparam int unsigned CTRL_REG_WRITE  = 2;
  localparam int unsigned CTRL_MEM_TO_REG = 3;
  localparam int unsigned CTRL_ALU_SRC    = 4;
  localparam int unsigned CTRL_ALU_OP_LO  = 5;
  localparam int unsigned CTRL_ALU_OP_HI  = 7;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // True when an instruction actually reads src and src names the given rd
  function automatic logic src_match(input logic uses, input logic [4:0] src,
                                     input logic [4:0] rd);
    return uses && (src == rd);
  endfunction

endpackage

// File: rtl/id_ex_hazard_reg_load_use_detect.sv
// Load-use hazard detection: a load in EX whose rd is read by the instruction in ID.
module load_use_detect
  import id_ex_hazard_reg_pkg::*;
(
  input  logic       ex_valid_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_addr_i,
  input  logic       id_valid_i,
  input  logic       id_uses_rs1_i,
  input  logic [4:0] id_rs1_addr_i,
  input  logic       id_uses_rs2_i,
  input  logic [4:0] id_rs2_addr_i,
  output logic       hazard_o
);

  // Hazard only for a real load writing a non-x0 register that ID consumes
  always_comb begin
    hazard_o = ex_valid_i && ex_mem_read_i && (ex_rd_addr_i != REG_ZERO) && id_valid_i &&
               (src_match(id_uses_rs1_i, id_rs1_addr_i, ex_rd_addr_i) ||
                src_match(id_uses_rs2_i, id_rs2_addr_i, ex_rd_addr_i));
  end

endmodule

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use bubble insertion, WB write-through
// bypass on capture, and a saturating bubble counter.
module id_ex_hazard_reg
  import id_ex_hazard_reg_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [XLEN-1:0]   id_pc_i,
  input  logic [XLEN-1:0]   id_rs1_data_i,
  input  logic [XLEN-1:0]   id_rs2_data_i,
  input  logic [XLEN-1:0]   id_imm_i,
  input  logic [4:0]        id_rs1_addr_i,
  input  logic [4:0]        id_rs2_addr_i,
  input  logic [4:0]        id_rd_addr_i,
  input  logic              id_uses_rs1_i,
  input  logic              id_uses_rs2_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic              flush_i,
  input  logic              wb_we_i,
  input  logic [4:0]        wb_rd_i,
  input  logic [XLEN-1:0]   wb_data_i,
  output logic              ex_valid_o,
  output logic [XLEN-1:0]   ex_pc_o,
  output logic [XLEN-1:0]   ex_rs1_data_o,
  output logic [XLEN-1:0]   ex_rs2_data_o,
  output logic [XLEN-1:0]   ex_imm_o,
  output logic [4:0]        ex_rs1_addr_o,
  output logic [4:0]        ex_rs2_addr_o,
  output logic [4:0]        ex_rd_addr_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  logic              valid_q,    valid_d;
  logic [XLEN-1:0]   pc_q,       pc_d;
  logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]   imm_q,      imm_d;
  logic [4:0]        rs1_addr_q, rs1_addr_d;
  logic [4:0]        rs2_addr_q, rs2_addr_d;
  logic [4:0]        rd_addr_q,  rd_addr_d;
  logic [CTRL_W-1:0] ctrl_q,     ctrl_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;

  logic              hazard;
  logic              capture;
  logic [XLEN-1:0]   rs1_fwd;
  logic [XLEN-1:0]   rs2_fwd;

  load_use_detect u_load_use_detect (
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (ctrl_q[CTRL_MEM_READ]),
    .ex_rd_addr_i  (rd_addr_q),
    .id_valid_i    (id_valid_i),
    .id_uses_rs1_i (id_uses_rs1_i),
    .id_rs1_addr_i (id_rs1_addr_i),
    .id_uses_rs2_i (id_uses_rs2_i),
    .id_rs2_addr_i (id_rs2_addr_i),
    .hazard_o      (hazard)
  );

  // Stall IF/ID only when the hazard will actually be resolved by a bubble
  always_comb begin
    stall_o = hazard && !flush_i;
    capture = !flush_i && !hazard && id_valid_i;
  end

  // Write-through bypass: the regfile read in ID misses the write retiring in WB
  always_comb begin
    rs1_fwd = id_rs1_data_i;
    rs2_fwd = id_rs2_data_i;
    if (wb_we_i && (wb_rd_i != REG_ZERO) && (wb_rd_i == id_rs1_addr_i)) rs1_fwd = wb_data_i;
    if (wb_we_i && (wb_rd_i != REG_ZERO) && (wb_rd_i == id_rs2_addr_i)) rs2_fwd = wb_data_i;
  end

  // Next EX contents: an all-zero bubble unless the ID instruction is captured
  always_comb begin
    valid_d    = 1'b0;
    pc_d       = '0;
    rs1_data_d = '0;
    rs2_data_d = '0;
    imm_d      = '0;
    rs1_addr_d = '0;
    rs2_addr_d = '0;
    rd_addr_d  = '0;
    ctrl_d     = '0;
    if (capture) begin
      valid_d    = 1'b1;
      pc_d       = id_pc_i;
      rs1_data_d = rs1_fwd;
      rs2_data_d = rs2_fwd;
      imm_d      = id_imm_i;
      rs1_addr_d = id_rs1_addr_i;
      rs2_addr_d = id_rs2_addr_i;
      rd_addr_d  = id_rd_addr_i;
      ctrl_d     = id_ctrl_i;
    end
  end

  // Saturating count of hazard bubbles; flushed hazards are not counted
  always_comb begin
    cnt_d = cnt_q;
    if (stall_o && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  // ID/EX state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_addr_q  <= '0;
      ctrl_q     <= '0;
      cnt_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
      rd_addr_q  <= rd_addr_d;
      ctrl_q     <= ctrl_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ex_valid_o    = valid_q;
  assign ex_pc_o       = pc_q;
  assign ex_rs1_data_o = rs1_data_q;
  assign ex_rs2_data_o = rs2_data_q;
  assign ex_imm_o      = imm_q;
  assign ex_rs1_addr_o = rs1_addr_q;
  assign ex_rs2_addr_o = rs2_addr_q;
  assign ex_rd_addr_o  = rd_addr_q;
  assign ex_ctrl_o     = ctrl_q;
  assign bubble_cnt_o  = cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Scoreboard bench for id_ex_hazard_reg: directed vectors push expected EX state,
// a monitor pops one entry per cycle and compares stall and registered outputs.
module tb_id_ex_hazard_reg;

  localparam logic [7:0] LW  = 8'h1D;
  localparam logic [7:0] ADD = 8'h04;
  localparam logic [7:0] LUI = 8'h14;

  typedef struct {
    logic        valid;
    logic [31:0] pc, r1d, r2d, imm;
    logic [4:0]  r1a, r2a, rd;
    logic        u1, u2;
    logic [7:0]  ctrl;
    logic        flush, wbwe;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
  } in_t;

  typedef struct {
    logic        stall, valid;
    logic [31:0] pc, r1d, r2d, imm;
    logic [4:0]  r1a, r2a, rd;
    logic [7:0]  ctrl;
    int          cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [31:0] id_pc = '0, id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
  logic [4:0]  id_rs1_addr = '0, id_rs2_addr = '0, id_rd_addr = '0;
  logic        id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
  logic [7:0]  id_ctrl = '0;
  logic        flush = 1'b0, wb_we = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;

  logic        ex_valid, stall;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic [7:0]  ex_ctrl;
  logic [3:0]  bubble_cnt;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  id_ex_hazard_reg #(.XLEN(32), .CTRL_W(8), .CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_pc_i(id_pc),
    .id_rs1_data_i(id_rs1_data), .id_rs2_data_i(id_rs2_data), .id_imm_i(id_imm),
    .id_rs1_addr_i(id_rs1_addr), .id_rs2_addr_i(id_rs2_addr), .id_rd_addr_i(id_rd_addr),
    .id_uses_rs1_i(id_uses_rs1), .id_uses_rs2_i(id_uses_rs2), .id_ctrl_i(id_ctrl),
    .flush_i(flush), .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
    .ex_valid_o(ex_valid), .ex_pc_o(ex_pc), .ex_rs1_data_o(ex_rs1_data),
    .ex_rs2_data_o(ex_rs2_data), .ex_imm_o(ex_imm), .ex_rs1_addr_o(ex_rs1_addr),
    .ex_rs2_addr_o(ex_rs2_addr), .ex_rd_addr_o(ex_rd_addr), .ex_ctrl_o(ex_ctrl),
    .stall_o(stall), .bubble_cnt_o(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t instr(input logic [31:0] pc, input logic [4:0] r1a, input logic [4:0] r2a,
                                input logic [4:0] rd, input logic u1, input logic u2,
                                input logic [7:0] ctrl, input logic [31:0] r1d,
                                input logic [31:0] r2d, input logic [31:0] imm);
    in_t i;
    i.valid = 1'b1; i.pc = pc; i.r1a = r1a; i.r2a = r2a; i.rd = rd; i.u1 = u1; i.u2 = u2;
    i.ctrl = ctrl; i.r1d = r1d; i.r2d = r2d; i.imm = imm;
    i.flush = 1'b0; i.wbwe = 1'b0; i.wbrd = '0; i.wbd = '0;
    return i;
  endfunction

  function automatic exp_t cap(input in_t i, input logic st, input int cnt);
    exp_t e;
    e.stall = st; e.valid = 1'b1; e.pc = i.pc; e.r1d = i.r1d; e.r2d = i.r2d; e.imm = i.imm;
    e.r1a = i.r1a; e.r2a = i.r2a; e.rd = i.rd; e.ctrl = i.ctrl; e.cnt = cnt;
    return e;
  endfunction

  function automatic exp_t bub(input logic st, input int cnt);
    exp_t e;
    e.stall = st; e.valid = 1'b0; e.pc = '0; e.r1d = '0; e.r2d = '0; e.imm = '0;
    e.r1a = '0; e.r2a = '0; e.rd = '0; e.ctrl = '0; e.cnt = cnt;
    return e;
  endfunction

  task automatic apply(input in_t i);
    id_valid = i.valid; id_pc = i.pc; id_rs1_data = i.r1d; id_rs2_data = i.r2d; id_imm = i.imm;
    id_rs1_addr = i.r1a; id_rs2_addr = i.r2a; id_rd_addr = i.rd;
    id_uses_rs1 = i.u1; id_uses_rs2 = i.u2; id_ctrl = i.ctrl;
    flush = i.flush; wb_we = i.wbwe; wb_rd = i.wbrd; wb_data = i.wbd;
  endtask

  // One ID cycle: drive after the edge, queue what stall and EX must show
  task automatic step(input in_t i, input exp_t e);
    @(posedge clk);
    #2;
    apply(i);
    q.push_back(e);
  endtask

  // Monitor: stall sampled mid-cycle, registered outputs just after the next edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall", {31'b0, stall}, {31'b0, e.stall});
        @(posedge clk);
        #1;
        chk("ex_valid", {31'b0, ex_valid}, {31'b0, e.valid});
        chk("ex_pc", ex_pc, e.pc);
        chk("ex_rs1_data", ex_rs1_data, e.r1d);
        chk("ex_rs2_data", ex_rs2_data, e.r2d);
        chk("ex_imm", ex_imm, e.imm);
        chk("ex_rs1_addr", {27'b0, ex_rs1_addr}, {27'b0, e.r1a});
        chk("ex_rs2_addr", {27'b0, ex_rs2_addr}, {27'b0, e.r2a});
        chk("ex_rd_addr", {27'b0, ex_rd_addr}, {27'b0, e.rd});
        chk("ex_ctrl", {24'b0, ex_ctrl}, {24'b0, e.ctrl});
        chk("bubble_cnt", {28'b0, bubble_cnt}, 32'(e.cnt));
      end
    end
  end

  initial begin
    in_t idle, lw5, add6, lw0, addx0, lui5, fl, bp, lw9, addr2;
    exp_t e;
    int c;

    idle  = instr('0, 0, 0, 0, 0, 0, '0, '0, '0, '0);
    idle.valid = 1'b0;
    lw5   = instr(32'h100, 5'd2, 5'd0, 5'd5, 1, 0, LW,  32'h1000, 32'h0, 32'h0);
    add6  = instr(32'h104, 5'd5, 5'd1, 5'd6, 1, 1, ADD, 32'h0, 32'h11, 32'h0);
    lw0   = instr(32'h108, 5'd2, 5'd0, 5'd0, 1, 0, LW,  32'h1000, 32'h0, 32'h8);
    addx0 = instr(32'h10C, 5'd0, 5'd1, 5'd6, 1, 1, ADD, 32'h0, 32'h11, 32'h0);
    lui5  = instr(32'h110, 5'd5, 5'd0, 5'd5, 0, 0, LUI, 32'h0, 32'h0, 32'h12345000);
    lw9   = instr(32'h118, 5'd3, 5'd0, 5'd9, 1, 0, LW,  32'h2000, 32'h0, 32'h4);
    addr2 = instr(32'h11C, 5'd2, 5'd9, 5'd1, 1, 1, ADD, 32'h22, 32'h0, 32'h0);

    // Reset state
    #3;
    chk("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
    chk("rst_cnt", {28'b0, bubble_cnt}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;

    // Reset asserted mid-stall drops the stall immediately
    step(lw5, cap(lw5, 0, 0));
    @(posedge clk);
    #2 apply(add6);
    #1 chk("pre_rst_stall", {31'b0, stall}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_stall", {31'b0, stall}, 32'd0);
    chk("midrst_ex_valid", {31'b0, ex_valid}, 32'd0);
    chk("midrst_cnt", {28'b0, bubble_cnt}, 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    apply(idle);

    // Load-use: one-cycle stall, bubble, then the add
    step(lw5,  cap(lw5, 0, 0));
    step(add6, bub(1, 1));
    step(add6, cap(add6, 0, 1));

    // x0 destination and non-using consumer never stall
    step(lw0,   cap(lw0, 0, 1));
    step(addx0, cap(addx0, 0, 1));
    step(lw5,   cap(lw5, 0, 1));
    step(lui5,  cap(lui5, 0, 1));

    // Flush beats hazard: no stall, bubble, counter unchanged
    step(lw5, cap(lw5, 0, 1));
    fl = add6; fl.flush = 1'b1;
    step(fl,   bub(0, 1));
    step(idle, bub(0, 1));

    // WB bypass on both sources
    bp = instr(32'h114, 5'd7, 5'd7, 5'd10, 1, 1, ADD, 32'h0, 32'h0, 32'h0);
    bp.wbwe = 1'b1; bp.wbrd = 5'd7; bp.wbd = 32'hDEADBEEF;
    e = cap(bp, 0, 1); e.r1d = 32'hDEADBEEF; e.r2d = 32'hDEADBEEF;
    step(bp, e);
    // wb_rd = x0 never bypasses
    bp.r1a = 5'd0; bp.r2a = 5'd0; bp.wbrd = 5'd0;
    step(bp, cap(bp, 0, 1));
    // Independent per-source bypass
    bp.r1a = 5'd7; bp.r2a = 5'd8; bp.r2d = 32'h55; bp.wbrd = 5'd7;
    e = cap(bp, 0, 1); e.r1d = 32'hDEADBEEF;
    step(bp, e);
    // Write enable low: stale data kept
    bp.r2a = 5'd7; bp.r2d = 32'h0; bp.wbwe = 1'b0;
    step(bp, cap(bp, 0, 1));

    // Hazard through rs2
    step(lw9,   cap(lw9, 0, 1));
    step(addr2, bub(1, 2));
    step(addr2, cap(addr2, 0, 2));

    // Saturation: 20 more load-use pairs on a 4-bit counter
    c = 2;
    for (int k = 0; k < 20; k++) begin
      step(lw5, cap(lw5, 0, c));
      c = (c < 15) ? c + 1 : 15;
      step(add6, bub(1, c));
    end
    step(add6, cap(add6, 0, 15));
    step(idle, bub(0, 15));

    // Drain the scoreboard with a bounded wait
    for (int n = 0; n < 20 && q.size() != 0; n++) @(posedge clk);
    repeat (2) @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_hazard_reg.md
Name: id_ex_hazard_reg

Overview:
- ID/EX pipeline register of the 5-stage core, directly upstream of the EX-stage forwarding muxes.
- Its registered rs1/rs2 data feed the muxes' register-file source input. Its registered rs addresses feed the forwarding unit that drives the mux selects.
- Owns load-use hazard detection: inserts a bubble and stalls IF/ID for one cycle.
- Also applies the WB-to-ID write-through bypass and counts hazard bubbles.

Parameters:
- XLEN, 32, datapath width.
- CTRL_W, 8, width of decoded control bundle.
- CNT_W, 16, width of saturating bubble counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- id_valid_i  in  1  ID holds a real instruction.
- id_pc_i  in  XLEN  ID instruction PC.
- id_rs1_data_i  in  XLEN  register file read port 1.
- id_rs2_data_i  in  XLEN  register file read port 2.
- id_imm_i  in  XLEN  decoded immediate.
- id_rs1_addr_i  in  5  source register 1 index.
- id_rs2_addr_i  in  5  source register 2 index.
- id_rd_addr_i  in  5  destination register index.
- id_uses_rs1_i  in  1  instruction reads rs1.
- id_uses_rs2_i  in  1  instruction reads rs2.
- id_ctrl_i  in  CTRL_W  decoded control bundle.
- flush_i  in  1  taken branch/jump resolved in EX.
- wb_we_i  in  1  WB register write enable.
- wb_rd_i  in  5  WB destination register.
- wb_data_i  in  XLEN  WB write data.
- ex_valid_o  out  1  EX holds a real instruction.
- ex_pc_o  out  XLEN  registered PC.
- ex_rs1_data_o  out  XLEN  registered rs1 data.
- ex_rs2_data_o  out  XLEN  registered rs2 data.
- ex_imm_o  out  XLEN  registered immediate.
- ex_rs1_addr_o  out  5  registered rs1 index.
- ex_rs2_addr_o  out  5  registered rs2 index.
- ex_rd_addr_o  out  5  registered rd index.
- ex_ctrl_o  out  CTRL_W  registered control bundle.
- stall_o  out  1  hold PC and IF/ID this cycle.
- bubble_cnt_o  out  CNT_W  saturating count of load-use bubbles.

Behaviour:
- Reset: rst_i high asynchronously clears every registered output to 0. This gives ex_valid_o=0 and bubble_cnt_o=0; stall_o is therefore 0. Reset mid-stall drops the stall in the same cycle.
- Latency: one clock, ID to EX.
- hazard (combinational) is true when all of the following hold:
  - ex_valid_o=1
  - ex_ctrl_o[CTRL_MEM_READ]=1
  - ex_rd_addr_o≠0
  - id_valid_i=1
  - (id_uses_rs1_i and id_rs1_addr_i==ex_rd_addr_o) or (id_uses_rs2_i and id_rs2_addr_i==ex_rd_addr_o)
- stall_o = hazard and not flush_i (combinational).
- Per-edge priority:
  1. flush_i: load a bubble; counter unchanged.
  2. hazard: load a bubble; counter increments.
  3. id_valid_i=0: load a bubble.
  4. Otherwise: capture all ID fields, ex_valid_o=1.
- Bubble definition: valid, ctrl, rd, rs1_addr, rs2_addr and all data fields forced to 0. The forwarding unit therefore never matches a bubble.
- Stall length: exactly one cycle per load-use pair. The next EX content is a bubble, so hazard deasserts the following cycle.
- WB bypass on capture: if wb_we_i=1, wb_rd_i≠0 and wb_rd_i==id_rs1_addr_i, capture wb_data_i instead of id_rs1_data_i. rs2 is handled independently in the same way.
- x0: rd=0 never raises a hazard; wb_rd_i=0 never bypasses.
- Counter: +1 on each non-flushed hazard edge; saturates at all-ones with no wrap.

Decomposition:
- Shared package (alongside the existing forward-select constants Reg_src/EX_src/MEM_src) holds:
  - control bundle bit indices: CTRL_MEM_READ=0, CTRL_MEM_WRITE=1, CTRL_REG_WRITE=2, CTRL_MEM_TO_REG=3, CTRL_ALU_SRC=4, CTRL_ALU_OP=7:5
  - REG_ZERO=5'd0
- One natural combinational sub-module: load_use_detect, which computes hazard from the EX and ID fields. The register, bypass and counter stay in the top block.

Test Plan:
- Reset mid-stall: EX holds lw x5, ID holds add x6,x5,x1; assert rst_i between edges -> stall_o and ex_valid_o are 0 immediately, bubble_cnt_o=0.
- Load-use: lw x5,0(x2) followed by add x6,x5,x1 -> stall_o=1 for exactly one cycle. EX shows bubble (ex_valid_o=0, ex_ctrl_o=0), then add with ex_rs1_addr_o=5; bubble_cnt_o=1.
- x0 and non-use: lw x0 followed by add x6,x0,x1; lw x5 followed by lui x5 (uses_rs1=0) -> stall_o stays 0, no bubble.
- Flush with hazard: hazard condition and flush_i=1 on the same cycle -> stall_o=0, EX loads bubble, bubble_cnt_o unchanged.
- WB bypass: regfile returns stale 0x00000000 for x7 while wb_we_i=1, wb_rd_i=7, wb_data_i=0xDEADBEEF, ID rs1=rs2=7 -> ex_rs1_data_o=ex_rs2_data_o=0xDEADBEEF. Repeat with wb_rd_i=0 -> both 0x00000000.
- Saturation with CNT_W=4: 20 load-use pairs -> bubble_cnt_o climbs to 4'hF and holds, no wrap.
